// File: rtl/axi2apb_multi_pkg.sv
// axi2apb_multi_pkg: shared FSM states, AXI response/burst codes and response merging
package axi2apb_multi_pkg;
  typedef enum logic [2:0] {IDLE, W_WAIT, SETUP, ACCESS, R_RESP, B_RESP} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a == RESP_DECERR || b == RESP_DECERR) ? RESP_DECERR :
           (a == RESP_SLVERR || b == RESP_SLVERR) ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi2apb_multi_apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles and flags the last one allowed without PREADY
import axi2apb_multi_pkg::*;
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic setup_i,
  input  logic access_i,
  output logic timeout_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout_o = access_i && cnt_q == LIMIT;
  // clear at SETUP, advance once per ACCESS cycle
  always_comb cnt_d = setup_i ? '0 : (access_i && !timeout_o) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/axi2apb_multi.sv
// axi2apb_multi: AXI4 to multi-port APB4 bridge splitting wide beats into APB sub-transfers
import axi2apb_multi_pkg::*;
module axi2apb_multi #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [AXI_ID_WIDTH-1:0]              aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]            aw_addr_i,
  input  logic [7:0]                           aw_len_i,
  input  logic [1:0]                           aw_burst_i,
  input  logic [2:0]                           aw_prot_i,
  input  logic                                 aw_valid_i,
  output logic                                 aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]            w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]          w_strb_i,
  input  logic                                 w_last_i,
  input  logic                                 w_valid_i,
  output logic                                 w_ready_o,
  output logic [AXI_ID_WIDTH-1:0]              b_id_o,
  output logic [1:0]                           b_resp_o,
  output logic                                 b_valid_o,
  input  logic                                 b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]              ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]            ar_addr_i,
  input  logic [7:0]                           ar_len_i,
  input  logic [1:0]                           ar_burst_i,
  input  logic [2:0]                           ar_prot_i,
  input  logic                                 ar_valid_i,
  output logic                                 ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0]              r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]            r_data_o,
  output logic [1:0]                           r_resp_o,
  output logic                                 r_last_o,
  output logic                                 r_valid_o,
  input  logic                                 r_ready_i,
  output logic [NUM_SLAVES-1:0]                psel_o,
  output logic                                 penable_o,
  output logic                                 pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]            paddr_o,
  output logic [APB_DATA_WIDTH-1:0]            pwdata_o,
  output logic [APB_DATA_WIDTH/8-1:0]          pstrb_o,
  output logic [2:0]                           pprot_o,
  input  logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]                pready_i,
  input  logic [NUM_SLAVES-1:0]                pslverr_i
);
  localparam int RATIO  = AXI_DATA_WIDTH / APB_DATA_WIDTH;
  localparam int SEL_W  = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int SUB_W  = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int AXI_SB = AXI_DATA_WIDTH / 8;
  localparam int APB_SB = APB_DATA_WIDTH / 8;
  state_e                    state_q, state_d;
  logic                      pref_w_q, pref_w_d, write_q, write_d;
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d, beat_q, beat_d;
  logic [1:0]                burst_q, burst_d, err_q, err_d;
  logic [2:0]                prot_q, prot_d;
  logic [SEL_W-1:0]          idx_q, idx_d;
  logic [SUB_W-1:0]          sub_q, sub_d;
  logic [RATIO-1:0]          mask_q, mask_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [AXI_SB-1:0]         wstrb_q, wstrb_d;
  logic [1:0]                beat_resp_q, beat_resp_d, burst_resp_q, burst_resp_d;
  logic                      grant_w, grant_r, apb_act, last_beat, acc_done, timeout;
  logic                      pready_sel, pslverr_sel, nxt_ok;
  logic [APB_DATA_WIDTH-1:0] prdata_sel;
  logic [AXI_ADDR_WIDTH-1:0] a_addr;
  logic [1:0]                a_burst, a_err, sub_resp;
  logic [SEL_W-1:0]          a_idx;
  logic [APB_ADDR_WIDTH-1:0] a_base, next_addr;
  logic [RATIO-1:0]          w_mask;
  logic [SUB_W-1:0]          w_first, nxt_lane;
  logic                      unused_ok;
  assign unused_ok  = ^{aw_addr_i, ar_addr_i, w_last_i};
  assign grant_w    = state_q == IDLE && aw_valid_i && (!ar_valid_i || pref_w_q);
  assign grant_r    = state_q == IDLE && ar_valid_i && !grant_w;
  assign a_addr     = grant_w ? aw_addr_i : ar_addr_i;
  assign a_burst    = grant_w ? aw_burst_i : ar_burst_i;
  assign a_idx      = a_addr[APB_ADDR_WIDTH +: SEL_W];
  assign a_err      = int'(a_idx) >= NUM_SLAVES ? RESP_DECERR : a_burst == BURST_WRAP ? RESP_SLVERR : RESP_OKAY;
  assign a_base     = a_addr[APB_ADDR_WIDTH-1:0] & ~APB_ADDR_WIDTH'(AXI_SB - 1);
  assign next_addr  = burst_q == BURST_INCR ? addr_q + APB_ADDR_WIDTH'(AXI_SB) : addr_q;
  assign last_beat  = beat_q == len_q;
  assign apb_act    = state_q == SETUP || state_q == ACCESS;
  assign acc_done   = state_q == ACCESS && (pready_sel || timeout);
  assign sub_resp   = pready_sel && !pslverr_sel ? RESP_OKAY : RESP_SLVERR;
  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .setup_i  (state_q == SETUP),
    .access_i (state_q == ACCESS),
    .timeout_o(timeout)
  );
  // route the selected slave's handshake and read data
  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int s = 0; s < NUM_SLAVES; s++) if (int'(idx_q) == s) begin
      prdata_sel  = prdata_i[s*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      pready_sel  = pready_i[s];
      pslverr_sel = pslverr_i[s];
    end
  end
  // lanes with live strobes and the next lane to visit in the current beat
  always_comb begin
    w_mask   = '0;
    w_first  = '0;
    nxt_ok   = 1'b0;
    nxt_lane = '0;
    for (int k = 0; k < RATIO; k++) w_mask[k] = |w_strb_i[k*APB_SB +: APB_SB];
    for (int k = RATIO - 1; k >= 0; k--) begin
      if (w_mask[k]) w_first = SUB_W'(k);
      if (mask_q[k] && k > int'(sub_q)) begin
        nxt_ok   = 1'b1;
        nxt_lane = SUB_W'(k);
      end
    end
  end
  // APB lane mux for the active sub-transfer
  always_comb begin
    pwdata_o = '0;
    pstrb_o  = '0;
    for (int k = 0; k < RATIO; k++) if (k == int'(sub_q)) begin
      pwdata_o = wdata_q[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      pstrb_o  = write_q && apb_act ? wstrb_q[k*APB_SB +: APB_SB] : '0;
    end
  end
  // bridge FSM: arbitration, beat sequencing, sub-transfer stepping, response merging
  always_comb begin
    state_d      = state_q;
    pref_w_d     = pref_w_q;
    write_d      = write_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_d       = beat_q;
    burst_d      = burst_q;
    err_d        = err_q;
    prot_d       = prot_q;
    idx_d        = idx_q;
    sub_d        = sub_q;
    mask_d       = mask_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    beat_resp_d  = beat_resp_q;
    burst_resp_d = burst_resp_q;
    case (state_q)
      IDLE: if (grant_w || grant_r) begin
        write_d      = grant_w;
        pref_w_d     = !grant_w;
        id_d         = grant_w ? aw_id_i : ar_id_i;
        len_d        = grant_w ? aw_len_i : ar_len_i;
        prot_d       = grant_w ? aw_prot_i : ar_prot_i;
        burst_d      = a_burst;
        addr_d       = a_base;
        idx_d        = a_idx;
        err_d        = a_err;
        beat_d       = '0;
        sub_d        = '0;
        mask_d       = '1;
        rdata_d      = '0;
        beat_resp_d  = a_err;
        burst_resp_d = RESP_OKAY;
        state_d      = grant_w ? W_WAIT : a_err != RESP_OKAY ? R_RESP : SETUP;
      end
      W_WAIT: if (w_valid_i) begin
        wdata_d     = w_data_i;
        wstrb_d     = w_strb_i;
        mask_d      = w_mask;
        sub_d       = w_first;
        beat_resp_d = err_q;
        if (err_q != RESP_OKAY || w_mask == '0) begin
          burst_resp_d = worst_resp(burst_resp_q, err_q);
          beat_d       = beat_q + 8'd1;
          addr_d       = next_addr;
          state_d      = last_beat ? B_RESP : W_WAIT;
        end else state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (acc_done) begin
        beat_resp_d = worst_resp(beat_resp_q, sub_resp);
        for (int k = 0; k < RATIO; k++) if (!write_q && k == int'(sub_q)) rdata_d[k*APB_DATA_WIDTH +: APB_DATA_WIDTH] = prdata_sel;
        if (nxt_ok) begin
          sub_d   = nxt_lane;
          state_d = SETUP;
        end else if (!write_q) state_d = R_RESP;
        else begin
          burst_resp_d = worst_resp(burst_resp_q, worst_resp(beat_resp_q, sub_resp));
          beat_d       = beat_q + 8'd1;
          addr_d       = next_addr;
          state_d      = last_beat ? B_RESP : W_WAIT;
        end
      end
      R_RESP: if (r_ready_i) begin
        beat_d      = beat_q + 8'd1;
        addr_d      = next_addr;
        sub_d       = '0;
        rdata_d     = '0;
        beat_resp_d = err_q;
        state_d     = last_beat ? IDLE : err_q != RESP_OKAY ? R_RESP : SETUP;
      end
      B_RESP: if (b_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk_i) begin
    state_q      <= rst_i ? IDLE : state_d;
    pref_w_q     <= rst_i ? 1'b1 : pref_w_d;
    write_q      <= rst_i ? 1'b0 : write_d;
    id_q         <= rst_i ? '0 : id_d;
    addr_q       <= rst_i ? '0 : addr_d;
    len_q        <= rst_i ? '0 : len_d;
    beat_q       <= rst_i ? '0 : beat_d;
    burst_q      <= rst_i ? '0 : burst_d;
    err_q        <= rst_i ? '0 : err_d;
    prot_q       <= rst_i ? '0 : prot_d;
    idx_q        <= rst_i ? '0 : idx_d;
    sub_q        <= rst_i ? '0 : sub_d;
    mask_q       <= rst_i ? '0 : mask_d;
    wdata_q      <= rst_i ? '0 : wdata_d;
    wstrb_q      <= rst_i ? '0 : wstrb_d;
    rdata_q      <= rst_i ? '0 : rdata_d;
    beat_resp_q  <= rst_i ? '0 : beat_resp_d;
    burst_resp_q <= rst_i ? '0 : burst_resp_d;
  end
  assign aw_ready_o = grant_w;
  assign ar_ready_o = grant_r;
  assign w_ready_o  = state_q == W_WAIT;
  assign b_valid_o  = state_q == B_RESP;
  assign b_id_o     = id_q;
  assign b_resp_o   = burst_resp_q;
  assign r_valid_o  = state_q == R_RESP;
  assign r_id_o     = id_q;
  assign r_data_o   = rdata_q;
  assign r_resp_o   = beat_resp_q;
  assign r_last_o   = r_valid_o && last_beat;
  assign psel_o     = apb_act ? NUM_SLAVES'(1) << idx_q : '0;
  assign penable_o  = state_q == ACCESS;
  assign pwrite_o   = apb_act && write_q;
  assign paddr_o    = addr_q + (APB_ADDR_WIDTH'(sub_q) << $clog2(APB_SB));
  assign pprot_o    = prot_q;
endmodule

// File: tb/tb_axi2apb_multi.sv
// tb_axi2apb_multi: directed checks of arbitration, lane splitting, decode errors, timeout and reset
module tb_axi2apb_multi;
  localparam int NS = 5;
  logic clk, rst;
  logic [3:0] aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len, w_strb;
  logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
  logic [2:0] aw_prot, ar_prot, pprot;
  logic aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
  logic ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic [63:0] w_data, r_data;
  logic [NS-1:0] psel, pready, pslverr;
  logic penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, rd_word;
  logic [3:0] pstrb;
  logic [NS*32-1:0] prdata;
  logic rdy_en, err_on;
  int log_n, base_n, sel_n, pen_n, base_sel, base_pen, n, errors, checks;
  logic [11:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic [3:0] log_strb [0:63];
  logic log_wr [0:63];

  axi2apb_multi #(.NUM_SLAVES(NS)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_burst_i(aw_burst),
    .aw_prot_i(aw_prot), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_burst_i(ar_burst),
    .ar_prot_i(ar_prot), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_word = 32'hAAAA0001 + 32'(log_n - base_n);
  assign prdata  = {NS{rd_word}};
  assign pready  = rdy_en ? '1 : '0;
  assign pslverr = (err_on && (log_n - base_n) == 1) ? '1 : '0;

  // APB slave-side monitor: logs every completed transfer
  always @(posedge clk) begin
    if (|psel) sel_n <= sel_n + 1;
    if (penable) pen_n <= pen_n + 1;
    if (penable && rdy_en) begin
      if (log_n < 64) begin
        log_addr[log_n] <= paddr;
        log_data[log_n] <= pwdata;
        log_strb[log_n] <= pstrb;
        log_wr[log_n]   <= pwrite;
      end
      log_n <= log_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [2:0] p);
    aw_id = id; aw_addr = a; aw_len = l; aw_burst = b; aw_prot = p; aw_valid = 1'b1;
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [2:0] p);
    ar_id = id; ar_addr = a; ar_len = l; ar_burst = b; ar_prot = p; ar_valid = 1'b1;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    int k;
    w_data = d; w_strb = s; w_last = l; w_valid = 1'b1; k = 0;
    @(negedge clk);
    while (!w_ready && k < 100) begin @(negedge clk); k++; end
    chk("w_ready", w_ready, 1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic wait_b();
    int k;
    k = 0;
    @(negedge clk);
    while (!b_valid && k < 200) begin @(negedge clk); k++; end
    chk("b_valid", b_valid, 1);
  endtask

  task automatic wait_r();
    int k;
    k = 0;
    @(negedge clk);
    while (!r_valid && k < 200) begin @(negedge clk); k++; end
    chk("r_valid", r_valid, 1);
  endtask

  task automatic b_hs();
    b_ready = 1'b1; @(posedge clk); #1; b_ready = 1'b0;
  endtask

  task automatic r_hs();
    r_ready = 1'b1; @(posedge clk); #1; r_ready = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; log_n = 0; base_n = 0; sel_n = 0; pen_n = 0;
    rst = 1'b1; rdy_en = 1'b1; err_on = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_prot = '0; aw_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_prot = '0; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {aw_ready, ar_ready, w_ready, b_valid, r_valid, penable, pwrite, psel, pstrb}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", {r_data, r_resp, r_last, b_resp}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // write INCR len=1 to slave 2 with a read pending: write wins
    aw_req(4'd3, 32'h2000, 8'd1, 2'b01, 3'b010);
    ar_req(4'd5, 32'h1008, 8'd0, 2'b01, 3'b000);
    base_n = log_n;
    @(negedge clk);
    chk("arb_write_first", {aw_ready, ar_ready}, 2'b10);
    @(posedge clk); #1; aw_valid = 1'b0;
    send_w(64'h1111_2222_3333_4444, 8'h0F, 1'b0);
    @(negedge clk);
    chk("w_setup_ctrl", {psel, penable, pwrite}, {5'b00100, 1'b0, 1'b1});
    chk("w_setup_addr", paddr, 12'h000);
    chk("w_setup_data", {pwdata, pstrb, pprot}, {32'h3333_4444, 4'hF, 3'b010});
    send_w(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    wait_b();
    chk("w_bresp", {b_resp, b_id}, {2'b00, 4'd3});
    chk("w_count", log_n - base_n, 3);
    chk("w_addrs", {log_addr[base_n], log_addr[base_n+1], log_addr[base_n+2]}, {12'h000, 12'h008, 12'h00C});
    chk("w_datas", {log_data[base_n+1], log_data[base_n+2]}, {32'h7777_8888, 32'h5555_6666});
    chk("w_strbs", {log_strb[base_n], log_strb[base_n+1], log_strb[base_n+2], log_wr[base_n], log_wr[base_n+2]}, {4'hF, 4'hF, 4'hF, 1'b1, 1'b1});
    b_hs();

    // both valid again: read is preferred now
    aw_req(4'd7, 32'h5000, 8'd1, 2'b01, 3'b000);
    @(negedge clk);
    chk("arb_read_next", {aw_ready, ar_ready}, 2'b01);
    @(posedge clk); #1; ar_valid = 1'b0;
    base_n = log_n;
    @(negedge clk);
    chk("r_setup_ctrl", {psel, penable, pwrite, pstrb}, {5'b00010, 1'b0, 1'b0, 4'h0});
    chk("r_setup_addr", paddr, 12'h008);
    n = 1;
    while (!r_valid && n < 100) begin @(negedge clk); n++; end
    chk("r_latency", n, 5);
    chk("r_data", r_data, 64'hAAAA0002_AAAA0001);
    chk("r_resp_last_id", {r_resp, r_last, r_id}, {2'b00, 1'b1, 4'd5});
    chk("r_addrs", {log_addr[base_n], log_addr[base_n+1]}, {12'h008, 12'h00C});
    @(negedge clk);
    chk("r_hold", {r_valid, r_data}, {1'b1, 64'hAAAA0002_AAAA0001});
    r_hs();

    // write to idx 5 >= NUM_SLAVES: drained with DECERR, no PSEL
    @(negedge clk);
    chk("dec_aw_ready", aw_ready, 1);
    base_sel = sel_n;
    @(posedge clk); #1; aw_valid = 1'b0;
    send_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    send_w(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1);
    wait_b();
    chk("dec_bresp", {b_resp, b_id}, {2'b11, 4'd7});
    chk("dec_no_psel", sel_n - base_sel, 0);
    b_hs();

    // slave never ready: each sub-transfer aborts after 16 ACCESS cycles
    rdy_en = 1'b0; base_pen = pen_n;
    ar_req(4'd2, 32'h1000, 8'd0, 2'b01, 3'b000);
    @(posedge clk); #1; ar_valid = 1'b0;
    wait_r();
    chk("tmo_resp", {r_resp, r_last}, {2'b10, 1'b1});
    chk("tmo_access_cycles", pen_n - base_pen, 32);
    r_hs();
    rdy_en = 1'b1;

    // PSLVERR on the second sub-transfer; unaligned address aligns down
    base_n = log_n; err_on = 1'b1;
    ar_req(4'd9, 32'h1004, 8'd0, 2'b01, 3'b000);
    @(posedge clk); #1; ar_valid = 1'b0;
    wait_r();
    chk("slverr_resp", {r_resp, r_id}, {2'b10, 4'd9});
    chk("slverr_lane0", r_data[31:0], 32'hAAAA0001);
    chk("slverr_align", log_addr[base_n], 12'h000);
    r_hs();
    err_on = 1'b0;

    // WRAP read: two SLVERR beats, no APB access
    base_sel = sel_n;
    ar_req(4'd4, 32'h1000, 8'd1, 2'b10, 3'b000);
    @(posedge clk); #1; ar_valid = 1'b0;
    wait_r();
    chk("wrap_beat0", {r_resp, r_last}, {2'b10, 1'b0});
    r_hs();
    @(negedge clk);
    chk("wrap_beat1", {r_valid, r_resp, r_last}, {1'b1, 2'b10, 1'b1});
    r_hs();
    chk("wrap_no_psel", sel_n - base_sel, 0);

    // FIXED write: strb 0 beat skipped, upper lane only on the second beat
    base_n = log_n;
    aw_req(4'd6, 32'h1010, 8'd1, 2'b00, 3'b001);
    @(posedge clk); #1; aw_valid = 1'b0;
    send_w(64'hDEAD_BEEF_0000_0000, 8'h00, 1'b0);
    send_w(64'hCAFE_F00D_1234_5678, 8'hF0, 1'b1);
    wait_b();
    chk("fixed_bresp", b_resp, 2'b00);
    chk("fixed_count", log_n - base_n, 1);
    chk("fixed_xfer", {log_addr[base_n], log_data[base_n], log_strb[base_n]}, {12'h014, 32'hCAFE_F00D, 4'hF});
    b_hs();

    // reset during ACCESS: APB drops, no response follows
    rdy_en = 1'b0;
    ar_req(4'd1, 32'h2000, 8'd0, 2'b01, 3'b000);
    @(posedge clk); #1; ar_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!penable && n < 20) begin @(negedge clk); n++; end
    chk("mid_penable", penable, 1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_apb", {psel, penable, r_valid}, 0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_resp", {r_valid, b_valid, psel}, 0);
    rdy_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
